// File: rtl/valu_beat_sequencer.sv
// Sequences one SOFT_THREAD-wide vALU instruction over a HARD_THREAD-wide lane
// array in SOFT_THREAD/HARD_THREAD beats. Build option: VALU_SEQ_SKIP_EMPTY_EN.

module valu_beat_lane #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] lane_out,
  input  logic [XLEN-1:0] vid,
  input  logic            is_vid,
  input  logic            zero,
  output logic [XLEN-1:0] res
);
  assign res = zero ? '0 : (is_vid ? vid : lane_out);
endmodule

module valu_beat_sequencer #(
  parameter int         SOFT_THREAD = 32,
  parameter int         HARD_THREAD = 8,
  parameter int         XLEN        = 32,
  parameter int         WREG        = 8,
  parameter int         DEPTH_WARP  = 3,
  parameter logic [5:0] FN_VMERGE   = 6'h1a,
  parameter logic [5:0] FN_VID      = 6'h1b
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [SOFT_THREAD*XLEN-1:0]   in1_i,
  input  logic [SOFT_THREAD*XLEN-1:0]   in2_i,
  input  logic [SOFT_THREAD-1:0]        mask_i,
  input  logic [5:0]                    ctrl_alu_fn_i,
  input  logic                          ctrl_reverse_i,
  input  logic                          ctrl_simt_stack_i,
  input  logic [DEPTH_WARP-1:0]         ctrl_wid_i,
  input  logic [WREG-1:0]               ctrl_reg_idxw_i,
  input  logic                          ctrl_wvd_i,
  output logic                          lane_valid_o,
  input  logic                          lane_ready_i,
  output logic [HARD_THREAD*XLEN-1:0]   lane_in1_o,
  output logic [HARD_THREAD*XLEN-1:0]   lane_in2_o,
  output logic [HARD_THREAD-1:0]        lane_mask_o,
  output logic [5:0]                    lane_fn_o,
  output logic                          lane_reverse_o,
  input  logic [HARD_THREAD*XLEN-1:0]   lane_out_i,
  input  logic [HARD_THREAD-1:0]        lane_cmp_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [SOFT_THREAD*XLEN-1:0]   wb_wvd_rd_o,
  output logic [SOFT_THREAD-1:0]        wvd_mask_o,
  output logic                          wvd_o,
  output logic [WREG-1:0]               reg_idxw_o,
  output logic [DEPTH_WARP-1:0]         warp_id_o,
  output logic                          out2simt_valid_o,
  input  logic                          out2simt_ready_i,
  output logic [SOFT_THREAD-1:0]        if_mask_o,
  output logic [DEPTH_WARP-1:0]         wid_o
);

  localparam int NUM_BEAT = SOFT_THREAD / HARD_THREAD;
  localparam int BW       = (NUM_BEAT > 1) ? $clog2(NUM_BEAT) : 1;
  localparam int SW       = HARD_THREAD * XLEN;

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t                                state_q, state_d;
  logic [BW-1:0]                         beat;
  logic [NUM_BEAT-1:0][SW-1:0]           in1_q, in2_q, res_q;
  logic [NUM_BEAT-1:0][HARD_THREAD-1:0]  mask_q, ifm_q;
  logic [5:0]                            fn_q;
  logic                                  rev_q, simt_q, wvd_q;
  logic [DEPTH_WARP-1:0]                 wid_q;
  logic [WREG-1:0]                       idx_q;

  logic                                  capture, beat_adv, last, skip, is_vid;
  logic [HARD_THREAD-1:0][XLEN-1:0]      beat_res;

  assign last   = (beat == BW'(NUM_BEAT - 1));
  assign is_vid = (fn_q == FN_VID);

`ifdef VALU_SEQ_SKIP_EMPTY_EN
  // Empty slices bypass the lanes; VMERGE/VID still need every element produced.
  assign skip = (state_q == RUN) && (mask_q[beat] == '0) &&
                (fn_q != FN_VMERGE) && !is_vid;
`else
  assign skip = 1'b0;
`endif

  for (genvar i = 0; i < HARD_THREAD; i++) begin : g_lane
    valu_beat_lane #(.XLEN(XLEN)) u_lane (
      .lane_out (lane_out_i[i*XLEN +: XLEN]),
      .vid      (XLEN'(int'(beat) * HARD_THREAD + i)),
      .is_vid   (is_vid),
      .zero     (skip),
      .res      (beat_res[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    in_ready_o       = 1'b0;
    lane_valid_o     = 1'b0;
    out_valid_o      = 1'b0;
    out2simt_valid_o = 1'b0;
    capture          = 1'b0;
    beat_adv         = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        lane_valid_o = !skip;
        beat_adv     = lane_ready_i || skip;
        if (beat_adv && last) state_d = OUT;
      end
      OUT: begin
        if (simt_q) begin
          out2simt_valid_o = 1'b1;
          if (out2simt_ready_i) state_d = IDLE;
        end else if (wvd_q) begin
          out_valid_o = 1'b1;
          if (out_ready_i) state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat   <= '0;
      in1_q  <= '0;
      in2_q  <= '0;
      mask_q <= '0;
      res_q  <= '0;
      ifm_q  <= '0;
      fn_q   <= '0;
      rev_q  <= 1'b0;
      simt_q <= 1'b0;
      wvd_q  <= 1'b0;
      wid_q  <= '0;
      idx_q  <= '0;
    end else if (capture) begin
      beat   <= '0;
      in1_q  <= in1_i;
      in2_q  <= in2_i;
      mask_q <= mask_i;
      fn_q   <= ctrl_alu_fn_i;
      rev_q  <= ctrl_reverse_i;
      simt_q <= ctrl_simt_stack_i;
      wvd_q  <= ctrl_wvd_i;
      wid_q  <= ctrl_wid_i;
      idx_q  <= ctrl_reg_idxw_i;
    end else if (beat_adv) begin
      res_q[beat] <= beat_res;
      ifm_q[beat] <= skip ? '0 : ~lane_cmp_i;
      if (!last) beat <= beat + 1'b1;
    end
  end

  assign lane_in1_o     = in1_q[beat];
  assign lane_in2_o     = in2_q[beat];
  assign lane_mask_o    = mask_q[beat];
  assign lane_fn_o      = fn_q;
  assign lane_reverse_o = rev_q;

  assign wb_wvd_rd_o = res_q;
  assign if_mask_o   = ifm_q;
  assign wvd_mask_o  = (fn_q == FN_VMERGE) ? '1 : mask_q;
  assign wvd_o       = wvd_q;
  assign reg_idxw_o  = idx_q;
  assign warp_id_o   = wid_q;
  assign wid_o       = wid_q;

endmodule

// File: tb/tb_valu_beat_sequencer.sv
// Directed bench for valu_beat_sequencer (SOFT=32, HARD=8, XLEN=32); lanes
// are modelled as a plain adder with a constant compare pattern.

module tb_valu_beat_sequencer;
  localparam int SOFT = 32, HARD = 8, XL = 32, WR = 8, DW = 3;
  localparam logic [5:0] FN_ADD = 6'h00, FN_VMERGE = 6'h1a, FN_VID = 6'h1b;

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready;
  logic [SOFT*XL-1:0] in1 = '0, in2 = '0;
  logic [SOFT-1:0] mask = '0;
  logic [5:0] fn = '0;
  logic rev = 0, simt = 0, wvd = 0;
  logic [DW-1:0] wid = '0;
  logic [WR-1:0] idx = '0;
  logic lane_valid, lane_ready = 1;
  logic [HARD*XL-1:0] lane_in1, lane_in2, lane_out;
  logic [HARD-1:0] lane_mask, cmp_val = '0;
  logic [5:0] lane_fn;
  logic lane_rev;
  logic out_valid, out_ready = 0;
  logic [SOFT*XL-1:0] wb;
  logic [SOFT-1:0] wvd_mask, if_mask;
  logic wvd_out;
  logic [WR-1:0] reg_idxw;
  logic [DW-1:0] warp_id, wid_out;
  logic simt_valid, simt_ready = 0;

  int nvec = 0, nerr = 0, cyc = 0, pulses = 0;

  always #5 clk = ~clk;

  always_comb begin
    lane_out = '0;
    for (int i = 0; i < HARD; i++)
      lane_out[i*XL +: XL] = lane_in1[i*XL +: XL] + lane_in2[i*XL +: XL];
  end

  valu_beat_sequencer #(.SOFT_THREAD(SOFT), .HARD_THREAD(HARD), .XLEN(XL),
                        .WREG(WR), .DEPTH_WARP(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in1_i(in1), .in2_i(in2), .mask_i(mask), .ctrl_alu_fn_i(fn),
    .ctrl_reverse_i(rev), .ctrl_simt_stack_i(simt), .ctrl_wid_i(wid),
    .ctrl_reg_idxw_i(idx), .ctrl_wvd_i(wvd),
    .lane_valid_o(lane_valid), .lane_ready_i(lane_ready),
    .lane_in1_o(lane_in1), .lane_in2_o(lane_in2), .lane_mask_o(lane_mask),
    .lane_fn_o(lane_fn), .lane_reverse_o(lane_rev),
    .lane_out_i(lane_out), .lane_cmp_i(cmp_val),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .wb_wvd_rd_o(wb), .wvd_mask_o(wvd_mask), .wvd_o(wvd_out),
    .reg_idxw_o(reg_idxw), .warp_id_o(warp_id),
    .out2simt_valid_o(simt_valid), .out2simt_ready_i(simt_ready),
    .if_mask_o(if_mask), .wid_o(wid_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send();
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  // Samples on falling edges until an output valid or in_ready shows up.
  task automatic wait_out(input int start);
    cyc = start;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cyc++;
      if (lane_valid) pulses++;
      if (out_valid || simt_valid || in_ready) return;
    end
  endtask

  function automatic logic [31:0] el(input int t);
    return wb[t*XL +: XL];
  endfunction

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_lane_valid", 64'(lane_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_simt_valid", 64'(simt_valid), 64'd0);
    chk("rst_wb0", 64'(el(0)), 64'd0);
    chk("rst_if_mask", 64'(if_mask), 64'd0);
    chk("rst_wvd_mask", 64'(wvd_mask), 64'd0);
    chk("rst_reg_idxw", 64'(reg_idxw), 64'd0);
    @(posedge clk); #1 rst_n = 1;

    // FN_ADD, in1[t]=t, in2[t]=100
    for (int t = 0; t < SOFT; t++) begin
      in1[t*XL +: XL] = 32'(t);
      in2[t*XL +: XL] = 32'd100;
    end
    mask = 32'hDEADBEEF; fn = FN_ADD; wvd = 1; simt = 0; wid = 3'd6; idx = 8'h5A;
    send();
    wait_out(0);
    chk("add_cycle", 64'(cyc), 64'd5);
    chk("add_pulses", 64'(pulses), 64'd4);
    chk("add_out_valid", 64'(out_valid), 64'd1);
    chk("add_simt_valid", 64'(simt_valid), 64'd0);
    for (int t = 0; t < SOFT; t++)
      chk($sformatf("add_el%0d", t), 64'(el(t)), 64'(100 + t));
    chk("add_wvd_mask", 64'(wvd_mask), 64'hDEADBEEF);
    chk("add_wvd", 64'(wvd_out), 64'd1);
    chk("add_reg_idxw", 64'(reg_idxw), 64'h5A);
    chk("add_warp_id", 64'(warp_id), 64'd6);
    out_ready = 1; @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    chk("add_drain_valid", 64'(out_valid), 64'd0);
    chk("add_drain_ready", 64'(in_ready), 64'd1);

    // FN_VID: element index replaces lane results
    mask = '1; fn = FN_VID;
    send();
    wait_out(0);
    chk("vid_cycle", 64'(cyc), 64'd5);
    chk("vid_el19", 64'(el(19)), 64'd19);
    for (int t = 0; t < SOFT; t += 5)
      chk($sformatf("vid_el%0d", t), 64'(el(t)), 64'(t));
    chk("vid_el31", 64'(el(31)), 64'd31);
    out_ready = 1; @(posedge clk); #1 out_ready = 0;

    // FN_VMERGE forces an all-ones write mask
    mask = 32'h0000FFFF; fn = FN_VMERGE;
    send();
    wait_out(0);
    chk("vmerge_wvd_mask", 64'(wvd_mask), 64'hFFFFFFFF);
    chk("vmerge_el20", 64'(el(20)), 64'd120);
    out_ready = 1; @(posedge clk); #1 out_ready = 0;

    // branch compare to SIMT stack
    mask = '1; fn = FN_ADD; simt = 1; wvd = 1; wid = 3'd5; cmp_val = 8'h0F;
    send();
    wait_out(0);
    chk("simt_cycle", 64'(cyc), 64'd5);
    chk("simt_valid", 64'(simt_valid), 64'd1);
    chk("simt_out_valid", 64'(out_valid), 64'd0);
    chk("simt_if_mask", 64'(if_mask), 64'hF0F0F0F0);
    chk("simt_wid", 64'(wid_out), 64'd5);
    @(negedge clk);
    chk("simt_hold", 64'(simt_valid), 64'd1);
    chk("simt_hold_out", 64'(out_valid), 64'd0);
    simt_ready = 1; @(posedge clk); #1 simt_ready = 0;
    @(negedge clk);
    chk("simt_drain", 64'(simt_valid), 64'd0);
    chk("simt_in_ready", 64'(in_ready), 64'd1);
    simt = 0; cmp_val = 8'h00;

    // lane stall for 3 cycles in beat 1, then writeback backpressure
    for (int t = 0; t < SOFT; t++) begin
      in1[t*XL +: XL] = 32'(3 * t);
      in2[t*XL +: XL] = 32'd7;
    end
    mask = 32'h12345678;
    send();
    @(posedge clk); #1 lane_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall_lv_%0d", k), 64'(lane_valid), 64'd1);
      chk($sformatf("stall_l0_%0d", k), 64'(lane_in1[31:0]), 64'd24);
      chk($sformatf("stall_l7_%0d", k), 64'(lane_in1[7*XL +: XL]), 64'd45);
      chk($sformatf("stall_mask_%0d", k), 64'(lane_mask), 64'h56);
    end
    @(posedge clk); #1 lane_ready = 1;
    wait_out(4);
    chk("stall_cycle", 64'(cyc), 64'd8);
    chk("stall_pulses", 64'(pulses), 64'd3);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("bp_valid_%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp_in_ready_%0d", k), 64'(in_ready), 64'd0);
      chk($sformatf("bp_el9_%0d", k), 64'(el(9)), 64'd34);
      chk($sformatf("bp_el31_%0d", k), 64'(el(31)), 64'd100);
      @(negedge clk);
    end
    out_ready = 1; @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    chk("bp_drain", 64'(out_valid), 64'd0);

    // no destination: silent return to IDLE
    wvd = 0; simt = 0;
    send();
    wait_out(0);
    chk("nodst_cycle", 64'(cyc), 64'd6);
    chk("nodst_in_ready", 64'(in_ready), 64'd1);
    chk("nodst_out_valid", 64'(out_valid), 64'd0);
    chk("nodst_simt_valid", 64'(simt_valid), 64'd0);

    // reset during beat 2 aborts the instruction
    wvd = 1;
    send();
    repeat (3) @(negedge clk);
    chk("mid_lane_valid", 64'(lane_valid), 64'd1);
    rst_n = 0; #1;
    chk("mid_rst_lane_valid", 64'(lane_valid), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_wb9", 64'(el(9)), 64'd0);
    @(posedge clk); #1 rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_quiet", 64'({out_valid, simt_valid, lane_valid}), 64'd0);
    end

    // sparse mask: beats 1 and 3 have no active threads
    for (int t = 0; t < SOFT; t++) begin
      in1[t*XL +: XL] = 32'(t);
      in2[t*XL +: XL] = 32'd100;
    end
    mask = 32'h00FF00FF; fn = FN_ADD; wvd = 1; cmp_val = 8'h0F;
    send();
    wait_out(0);
    chk("sparse_cycle", 64'(cyc), 64'd5);
    chk("sparse_el0", 64'(el(0)), 64'd100);
    chk("sparse_el16", 64'(el(16)), 64'd116);
`ifdef VALU_SEQ_SKIP_EMPTY_EN
    chk("sparse_pulses", 64'(pulses), 64'd2);
    chk("sparse_el8", 64'(el(8)), 64'd0);
    chk("sparse_el31", 64'(el(31)), 64'd0);
    chk("sparse_if_mask", 64'(if_mask), 64'h00F000F0);
`else
    chk("sparse_pulses", 64'(pulses), 64'd4);
    chk("sparse_el8", 64'(el(8)), 64'd108);
    chk("sparse_el31", 64'(el(31)), 64'd131);
    chk("sparse_if_mask", 64'(if_mask), 64'hF0F0F0F0);
`endif
    chk("sparse_wvd_mask", 64'(wvd_mask), 64'h00FF00FF);
    out_ready = 1; @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    chk("sparse_drain", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
